// File: rtl/bcd_pkg.sv
// Shared definitions for the sequential BCD-to-binary converter.
// Holds the FSM state enumeration, default geometry and width constants.
package bcd_pkg;

    localparam int unsigned NDIG_DEF = 5;             // BCD input digits
    localparam int unsigned NBIN_DEF = 17;            // shift iterations
    localparam int unsigned DIG_W    = 4;             // bits per BCD digit
    localparam int unsigned BCD_W    = DIG_W * NDIG_DEF;
    localparam int unsigned OUT_W    = 16;            // clamped result width

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_e;

endpackage

// File: rtl/bcd_to_bin16_seq_if.sv
// Request/result bus of the BCD-to-binary converter.
//   in_valid/in_ready/in_bcd : conversion request handshake and packed BCD operand
//   out_valid                : one-cycle pulse marking a new result
//   out_bin/out_ovf/out_err  : result, overflow and bad-digit flags (held)
// master: requester side; slave: converter side.
interface bcd_to_bin16_seq_if
    import bcd_pkg::*;
#(
    parameter int unsigned NDIG = NDIG_DEF
);

    logic                    in_valid;
    logic                    in_ready;
    logic [DIG_W*NDIG-1:0]   in_bcd;
    logic                    out_valid;
    logic [OUT_W-1:0]        out_bin;
    logic                    out_ovf;
    logic                    out_err;

    modport master (
        output in_valid,
        output in_bcd,
        input  in_ready,
        input  out_valid,
        input  out_bin,
        input  out_ovf,
        input  out_err
    );

    modport slave (
        input  in_valid,
        input  in_bcd,
        output in_ready,
        output out_valid,
        output out_bin,
        output out_ovf,
        output out_err
    );

endinterface

// File: rtl/bcd_digit_adj.sv
// Per-digit correction for reverse double-dabble: a nibble that is 8 or more
// after the right shift had a ten carried into it, so subtract 3 (mod 16).
//   d_in    : shifted BCD nibble
//   d_out_c : corrected nibble (combinational)
module bcd_digit_adj
    import bcd_pkg::*;
(
    input  logic [DIG_W-1:0] d_in,
    output logic [DIG_W-1:0] d_out_c
);

    always_comb begin
        d_out_c = d_in;
        if (d_in >= DIG_W'(8)) begin
            d_out_c = d_in - DIG_W'(3);
        end
    end

endmodule

// File: rtl/bcd_to_bin16_seq.sv
// Sequential packed-BCD to 16-bit binary converter (reverse double-dabble),
// one shift iteration per clock, NBIN iterations per conversion.
//   clk : sole clock, rising edge
//   rst : synchronous active-high reset
//   bus : request/result interface (slave side)
module bcd_to_bin16_seq
    import bcd_pkg::*;
#(
    parameter int unsigned NDIG = NDIG_DEF,
    parameter int unsigned NBIN = NBIN_DEF
) (
    input  logic                clk,
    input  logic                rst,
    bcd_to_bin16_seq_if.slave   bus
);

    localparam int unsigned W_BCD = DIG_W * NDIG;
    localparam int unsigned CNT_W = $clog2(NBIN + 1);

    state_e             state_q,     state_d;
    logic [W_BCD-1:0]   bcd_q,       bcd_d;
    logic [NBIN-1:0]    bin_q,       bin_d;
    logic [CNT_W-1:0]   cnt_q,       cnt_d;
    logic               err_q,       err_d;
    logic               in_ready_q,  in_ready_d;
    logic               out_valid_q, out_valid_d;
    logic [OUT_W-1:0]   out_bin_q,   out_bin_d;
    logic               out_ovf_q,   out_ovf_d;
    logic               out_err_q,   out_err_d;

    logic [W_BCD-1:0]   bcd_shift_c;
    logic [W_BCD-1:0]   bcd_adj_c;
    logic [NBIN-1:0]    bin_shift_c;
    logic               in_bad_c;
    logic               accept_c;

    // Right shift of the whole {bcd, bin} register by one bit.
    assign bcd_shift_c = bcd_q >> 1;
    assign bin_shift_c = {bcd_q[0], bin_q[NBIN-1:1]};

    // Digit correction after the shift, one adjuster per digit.
    for (genvar g = 0; g < NDIG; g++) begin : g_dig
        bcd_digit_adj u_adj (
            .d_in    (bcd_shift_c[DIG_W*g +: DIG_W]),
            .d_out_c (bcd_adj_c[DIG_W*g +: DIG_W])
        );
    end

    // Any nibble above 9 marks the operand as invalid BCD.
    always_comb begin
        in_bad_c = 1'b0;
        for (int unsigned i = 0; i < NDIG; i++) begin
            if (bus.in_bcd[DIG_W*i +: DIG_W] > DIG_W'(9)) begin
                in_bad_c = 1'b1;
            end
        end
    end

    assign accept_c = bus.in_valid & in_ready_q;

    // Next-state and datapath control.
    always_comb begin
        state_d   = state_q;
        bcd_d     = bcd_q;
        bin_d     = bin_q;
        cnt_d     = cnt_q;
        err_d     = err_q;
        out_bin_d = out_bin_q;
        out_ovf_d = out_ovf_q;
        out_err_d = out_err_q;

        unique case (state_q)
            ST_IDLE: begin
                if (accept_c) begin
                    state_d = ST_SHIFT;
                    bcd_d   = bus.in_bcd;
                    bin_d   = '0;
                    cnt_d   = CNT_W'(NBIN);
                    err_d   = in_bad_c;
                end
            end
            ST_SHIFT: begin
                bcd_d = bcd_adj_c;
                bin_d = bin_shift_c;
                cnt_d = cnt_q - CNT_W'(1);
                // Last iteration: publish the result from this shift.
                if (cnt_q == CNT_W'(1)) begin
                    state_d   = ST_DONE;
                    out_err_d = err_q;
                    out_bin_d = err_q ? '0 : bin_shift_c[OUT_W-1:0];
                    out_ovf_d = err_q ? 1'b0 : bin_shift_c[NBIN-1];
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Handshake flags are registered decodes of the next state.
        in_ready_d  = (state_d == ST_IDLE);
        out_valid_d = (state_d == ST_DONE);
    end

    // State and datapath registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            bcd_q       <= '0;
            bin_q       <= '0;
            cnt_q       <= '0;
            err_q       <= 1'b0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            out_bin_q   <= '0;
            out_ovf_q   <= 1'b0;
            out_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            bcd_q       <= bcd_d;
            bin_q       <= bin_d;
            cnt_q       <= cnt_d;
            err_q       <= err_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            out_bin_q   <= out_bin_d;
            out_ovf_q   <= out_ovf_d;
            out_err_q   <= out_err_d;
        end
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = out_valid_q;
    assign bus.out_bin   = out_bin_q;
    assign bus.out_ovf   = out_ovf_q;
    assign bus.out_err   = out_err_q;

endmodule

// File: tb/tb_bcd_to_bin16_seq.sv
// Self-checking bench for bcd_to_bin16_seq against a decimal reference model.
module tb_bcd_to_bin16_seq;

    logic clk;
    logic rst;
    int   checks;
    int   errors;

    bcd_to_bin16_seq_if #(.NDIG(5)) bus ();

    bcd_to_bin16_seq #(.NDIG(5), .NBIN(17)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Decimal value of the digits, clamped to 16 bits; invalid digits force zero.
    function automatic void ref_model(input logic [19:0] b, output logic [15:0] eb,
                                      output logic eo, output logic ee);
        int unsigned v;
        int unsigned d;
        v  = 0;
        ee = 1'b0;
        for (int i = 4; i >= 0; i--) begin
            d = (b >> (4 * i)) & 32'hF;
            if (d > 9) ee = 1'b1;
            v = v * 10 + d;
        end
        if (ee) begin
            eb = 16'h0;
            eo = 1'b0;
        end else begin
            eb = 16'(v % 65536);
            eo = (v > 65535);
        end
    endfunction

    function automatic logic [19:0] rand_bcd(input bit bad);
        logic [19:0] r;
        int unsigned k;
        for (int i = 0; i < 5; i++) r[4*i +: 4] = 4'($urandom_range(0, 9));
        if (bad) begin
            k = $urandom_range(0, 4);
            r[4*k +: 4] = 4'($urandom_range(10, 15));
        end
        return r;
    endfunction

    // Issue one request and wait for its result; lat = edges from accept to out_valid.
    task automatic run_conv(input logic [19:0] b, output logic [15:0] ob,
                            output logic oo, output logic oe, output int lat);
        int n;
        @(negedge clk);
        n = 0;
        while (bus.in_ready !== 1'b1 && n < 50) begin
            @(negedge clk);
            n++;
        end
        bus.in_valid = 1'b1;
        bus.in_bcd   = b;
        @(negedge clk);
        bus.in_valid = 1'b0;
        bus.in_bcd   = rand_bcd(1'b0);
        lat = 0;
        while (bus.out_valid !== 1'b1 && lat < 40) begin
            @(negedge clk);
            bus.in_bcd = rand_bcd(1'b1);
            lat++;
        end
        ob = bus.out_bin;
        oo = bus.out_ovf;
        oe = bus.out_err;
    endtask

    task automatic test_reset();
        rst          = 1'b1;
        bus.in_valid = 1'b1;
        bus.in_bcd   = 20'h00005;
        repeat (3) @(negedge clk);
        rst          = 1'b0;
        bus.in_valid = 1'b0;
        checks++;
        if (bus.in_ready !== 1'b1) begin
            errors++; $display("FAIL reset_in_ready got %b want 1", bus.in_ready);
        end
        checks++;
        if (bus.out_valid !== 1'b0) begin
            errors++; $display("FAIL reset_out_valid got %b want 0", bus.out_valid);
        end
        checks++;
        if ({bus.out_err, bus.out_ovf, bus.out_bin} !== 18'h0) begin
            errors++; $display("FAIL reset_outputs got err=%b ovf=%b bin=%h want 0",
                               bus.out_err, bus.out_ovf, bus.out_bin);
        end
        // in_valid was high during the reset edges; nothing must have been accepted.
        for (int i = 0; i < 25; i++) begin
            @(negedge clk);
            checks++;
            if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
                errors++; $display("FAIL reset_no_accept cyc %0d got valid=%b ready=%b want 0/1",
                                   i, bus.out_valid, bus.in_ready);
            end
        end
    endtask

    task automatic test_directed();
        logic [19:0] vec [7];
        logic [15:0] ob, eb;
        logic        oo, oe, eo, ee;
        int          lat;
        vec = '{20'h65535, 20'h99999, 20'h65536, 20'h00000, 20'h1A000, 20'h00001, 20'h09999};
        for (int i = 0; i < 7; i++) begin
            ref_model(vec[i], eb, eo, ee);
            run_conv(vec[i], ob, oo, oe, lat);
            checks++;
            if (lat !== 17) begin
                errors++; $display("FAIL dir_latency in=%h got %0d want 17", vec[i], lat);
            end
            checks++;
            if ({oe, oo, ob} !== {ee, eo, eb}) begin
                errors++; $display("FAIL dir_result in=%h got err=%b ovf=%b bin=%h want err=%b ovf=%b bin=%h",
                                   vec[i], oe, oo, ob, ee, eo, eb);
            end
            // out_valid is a single-cycle pulse, then the converter is ready again.
            @(negedge clk);
            checks++;
            if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
                errors++; $display("FAIL dir_pulse in=%h got valid=%b ready=%b want 0/1",
                                   vec[i], bus.out_valid, bus.in_ready);
            end
            checks++;
            if ({bus.out_err, bus.out_ovf, bus.out_bin} !== {ee, eo, eb}) begin
                errors++; $display("FAIL dir_hold in=%h got bin=%h want %h", vec[i], bus.out_bin, eb);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [17:0] exp_q [$];
        logic [17:0] prev, cur, e;
        logic [19:0] nb;
        logic [15:0] eb;
        logic        eo, ee;
        int          got, low_run;
        got     = 0;
        low_run = 0;
        @(negedge clk);
        prev = {bus.out_err, bus.out_ovf, bus.out_bin};
        bus.in_valid = 1'b1;
        for (int cyc = 0; cyc < 200 && got < 4; cyc++) begin
            if (cyc != 0) @(negedge clk);
            cur = {bus.out_err, bus.out_ovf, bus.out_bin};
            if (bus.out_valid === 1'b1) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++; $display("FAIL b2b_unexpected got %h want no result", cur);
                end else begin
                    e = exp_q.pop_front();
                    if (cur !== e) begin
                        errors++; $display("FAIL b2b_result got %h want %h", cur, e);
                    end
                end
                got++;
            end else begin
                checks++;
                if (cur !== prev) begin
                    errors++; $display("FAIL b2b_stable cyc %0d got %h want %h", cyc, cur, prev);
                end
            end
            prev = cur;
            if (bus.in_ready === 1'b1) begin
                if (low_run > 0) begin
                    checks++;
                    if (low_run !== 18) begin
                        errors++; $display("FAIL b2b_busy_len got %0d want 18", low_run);
                    end
                end
                low_run = 0;
            end else begin
                low_run++;
            end
            nb = rand_bcd($urandom_range(0, 3) == 0);
            bus.in_bcd = nb;
            if (bus.in_ready === 1'b1) begin
                ref_model(nb, eb, eo, ee);
                exp_q.push_back({ee, eo, eb});
            end
        end
        bus.in_valid = 1'b0;
        checks++;
        if (got !== 4) begin
            errors++; $display("FAIL b2b_count got %0d want 4", got);
        end
    endtask

    task automatic test_reset_abort();
        logic [15:0] ob;
        logic        oo, oe;
        int          lat, n;
        run_conv(20'h00777, ob, oo, oe, lat);
        @(negedge clk);
        n = 0;
        while (bus.in_ready !== 1'b1 && n < 50) begin
            @(negedge clk);
            n++;
        end
        bus.in_valid = 1'b1;
        bus.in_bcd   = 20'h12345;
        @(negedge clk);
        bus.in_valid = 1'b0;
        repeat (8) @(negedge clk);
        rst          = 1'b1;
        bus.in_valid = 1'b1;
        @(negedge clk);
        rst          = 1'b0;
        bus.in_valid = 1'b0;
        checks++;
        if ({bus.out_valid, bus.out_err, bus.out_ovf, bus.out_bin} !== 19'h0) begin
            errors++; $display("FAIL abort_outputs got valid=%b err=%b ovf=%b bin=%h want 0",
                               bus.out_valid, bus.out_err, bus.out_ovf, bus.out_bin);
        end
        checks++;
        if (bus.in_ready !== 1'b1) begin
            errors++; $display("FAIL abort_in_ready got %b want 1", bus.in_ready);
        end
        for (int i = 0; i < 25; i++) begin
            @(negedge clk);
            checks++;
            if (bus.out_valid !== 1'b0) begin
                errors++; $display("FAIL abort_no_valid cyc %0d got 1 want 0", i);
            end
        end
        run_conv(20'h00042, ob, oo, oe, lat);
        checks++;
        if ({oe, oo, ob} !== {1'b0, 1'b0, 16'h002A} || lat !== 17) begin
            errors++; $display("FAIL abort_after got err=%b ovf=%b bin=%h lat=%0d want 0 0 002a 17",
                               oe, oo, ob, lat);
        end
    endtask

    task automatic test_random();
        logic [19:0] b;
        logic [15:0] ob, eb;
        logic        oo, oe, eo, ee;
        int          lat;
        for (int i = 0; i < 1000; i++) begin
            b = rand_bcd($urandom_range(0, 7) == 0);
            ref_model(b, eb, eo, ee);
            run_conv(b, ob, oo, oe, lat);
            checks++;
            if ({oe, oo, ob} !== {ee, eo, eb} || lat !== 17) begin
                errors++; $display("FAIL rand in=%h got err=%b ovf=%b bin=%h lat=%0d want err=%b ovf=%b bin=%h lat=17",
                                   b, oe, oo, ob, lat, ee, eo, eb);
            end
        end
    endtask

    initial begin
        checks       = 0;
        errors       = 0;
        rst          = 1'b1;
        bus.in_valid = 1'b0;
        bus.in_bcd   = '0;
        test_reset();
        test_directed();
        test_back_to_back();
        test_reset_abort();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/bcd_to_bin16_seq.md
BCD_TO_BIN16_SEQ -- requirements
Module: bcd_to_bin16_seq

Interface
REQ-001 SHALL have parameters: NDIG, default 5, number of BCD input digits; NBIN, default 17, number of shift iterations (result width before clamp).
REQ-002 SHALL have port clk, input, 1, sole clock; all logic on rising edge.
REQ-003 SHALL have port rst, input, 1, synchronous active-high reset.
REQ-004 SHALL have port in_valid, input, 1, request to convert in_bcd.
REQ-005 SHALL have port in_ready, output, 1, high only in IDLE; transfer on in_valid & in_ready at a rising edge.
REQ-006 SHALL have port in_bcd, input, 4*NDIG (20), packed BCD, digit 0 in bits [3:0].
REQ-007 SHALL have port out_valid, output, 1, one-cycle pulse marking a new result.
REQ-008 SHALL have port out_bin, output, 16, binary result, held until next out_valid.
REQ-009 SHALL have port out_ovf, output, 1, value > 65535, held with out_bin.
REQ-010 SHALL have port out_err, output, 1, some input nibble > 9, held with out_bin.

Function
REQ-011 SHALL implement reverse double-dabble: working register {bcd[19:0], bin[16:0]}; per iteration, shift the whole register right 1, then each BCD nibble >= 8 gets 3 subtracted (mod 16).
REQ-012 SHALL use states IDLE, SHIFT, DONE; IDLE->SHIFT on accept; SHIFT->DONE after exactly NBIN (17) iterations; DONE->IDLE unconditionally after one cycle.
REQ-013 SHALL, on accept edge E0, load in_bcd into bcd, clear bin, load iteration counter, and latch err = OR over nibbles (nibble > 9).
REQ-014 SHALL perform one iteration at each edge E1..E17, registering out_bin/out_ovf/out_err and entering DONE at E17.
REQ-015 SHALL assert out_valid only during DONE (E17..E18); in_ready returns high after E18; minimum accept-to-accept spacing 18 cycles.
REQ-016 SHALL set out_ovf = bin[16] and out_bin = bin[15:0] when err = 0.
REQ-017 SHALL, when err = 1, force out_bin = 0 and out_ovf = 0, still taking the full 17-iteration latency.
REQ-018 SHALL ignore in_valid and in_bcd while in SHIFT or DONE (no queuing, no effect on the result in progress).
REQ-019 SHALL keep out_bin/out_ovf/out_err stable outside the E17 update edge.

Reset
REQ-020 SHALL, on rst high at an edge, go to IDLE, abort any conversion, and clear out_valid, out_bin, out_ovf, out_err, counter and working register to 0; in_ready = 1 from the following cycle.
REQ-021 SHALL give rst priority over a simultaneous in_valid (no accept on the reset edge).

Structure
REQ-022 SHALL place the state enumeration, NDIG/NBIN defaults and the BCD/binary width constants in a shared package bcd_pkg.
REQ-023 SHALL instantiate a combinational sub-module bcd_digit_adj (4-bit in, 4-bit out: x >= 8 ? x-3 : x) once per digit.

Verification
REQ-024 SHALL check in_bcd = 0x65535 -> out_bin = 0xFFFF, ovf = 0, err = 0, out_valid 17 edges after accept.
REQ-025 SHALL check in_bcd = 0x99999 -> out_bin = 0x869F, ovf = 1, err = 0; 0x65536 -> out_bin = 0x0000, ovf = 1.
REQ-026 SHALL check in_bcd = 0x00000 -> 0x0000, and 0x1A000 -> out_bin = 0, err = 1, ovf = 0.
REQ-027 SHALL check in_valid held high continuously with changing data -> only values present at accept edges converted, in_ready low 18 cycles per conversion.
REQ-028 SHALL check rst asserted at iteration 8 -> no out_valid, outputs 0, then 0x00042 after reset -> 0x002A.
REQ-029 SHALL check random 5-digit BCD values (1000 samples) against a reference decimal model.
